em_stage: RTL and testbench

- Execute/memory stage that consumes the latched FD→EM pipeline signals: operands, ALU control, register addresses, write-back enable, memory read/write enables and store data.
- Computes the ALU result and runs load/store accesses to data memory over a req/ack handshake.
- Holds the front end with `stall` while an access is outstanding.
- Drives a registered register-file write-back port.

---
 rtl/em_stage_if.sv | 21 ++
 rtl/em_stage.sv | 171 +++++++++++++++++
 tb/tb_em_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/em_stage_if.sv
// Data-memory req/ack bus between the execute/memory stage and data memory.
interface em_stage_if #(
   parameter int ADDR_W = 8
);
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [9:0]        dmem_wdata;
   logic [9:0]        dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/em_stage.sv
// Execute/memory stage: 10-bit ALU, req/ack load/store with timeout abort,
// and a registered register-file write-back port.
module em_stage #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] gp_rdata1_address,
   input  logic [2:0] gp_rdata2_address,
   input  logic [9:0] aluA,
   input  logic [9:0] aluB,
   input  logic [2:0] alu_ctrl,
   input  logic       gp_reg_wb,
   input  logic       mem_we,
   input  logic       mem_re,
   input  logic [9:0] store_data,
   em_stage_if.master dmem,
   output logic       stall,
   output logic       wb_en,
   output logic [2:0] wb_addr,
   output logic [9:0] wb_data,
   output logic [2:0] fwd_src,
   output logic       bus_err
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

   function automatic logic [9:0] alu_f(input logic [9:0] a, input logic [9:0] b,
                                        input logic [2:0] op);
      logic [9:0] r;
      case (op)
         3'b000:  r = a + b;
         3'b001:  r = a - b;
         3'b010:  r = a & b;
         3'b011:  r = a | b;
         3'b100:  r = a ^ b;
         3'b101:  r = (b[3:0] >= 4'd10) ? 10'd0 : (a << b[3:0]);
         3'b110:  r = (b[3:0] >= 4'd10) ? 10'd0 : (a >> b[3:0]);
         3'b111:  r = {9'd0, ($signed(a) < $signed(b))};
         default: r = 10'd0;
      endcase
      return r;
   endfunction

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic              req_r, req_s, we_r, we_s, stall_r, stall_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [9:0]        wdata_r, wdata_s, wb_data_r, wb_data_s;
   logic              wb_en_r, wb_en_s, bus_err_r, bus_err_s;
   logic [2:0]        wb_addr_r, wb_addr_s, fwd_r, fwd_s;
   logic              lat_wb_r, lat_wb_s;
   logic [2:0]        lat_dest_r, lat_dest_s;
   logic [9:0]        alu_s;

   assign alu_s = alu_f(aluA, aluB, alu_ctrl);

   // Next-state and next-output logic; held values by default, strobes default low.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      req_s      = req_r;
      we_s       = we_r;
      stall_s    = stall_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      wb_en_s    = 1'b0;
      wb_addr_s  = wb_addr_r;
      wb_data_s  = wb_data_r;
      fwd_s      = fwd_r;
      bus_err_s  = 1'b0;
      lat_wb_s   = lat_wb_r;
      lat_dest_s = lat_dest_r;
      case (state_r)
         IDLE: begin
            fwd_s = gp_rdata1_address;
            if (mem_we || mem_re) begin
               state_s    = MEM_WAIT;
               req_s      = 1'b1;
               stall_s    = 1'b1;
               cnt_s      = '0;
               we_s       = mem_we;
               addr_s     = alu_s[ADDR_W-1:0];
               wdata_s    = store_data;
               lat_wb_s   = gp_reg_wb & ~mem_we;
               lat_dest_s = gp_rdata2_address;
            end else begin
               wb_en_s   = gp_reg_wb;
               wb_addr_s = gp_rdata2_address;
               wb_data_s = alu_s;
            end
         end
         MEM_WAIT: begin
            // Ack takes precedence over the timeout on the same edge.
            if (dmem.dmem_ack) begin
               state_s = IDLE;
               req_s   = 1'b0;
               stall_s = 1'b0;
               if (lat_wb_r) begin
                  wb_en_s   = 1'b1;
                  wb_addr_s = lat_dest_r;
                  wb_data_s = dmem.dmem_rdata;
               end else begin
                  wb_en_s = 1'b0;
               end
            end else if (cnt_r == CNT_LAST) begin
               state_s   = IDLE;
               req_s     = 1'b0;
               stall_s   = 1'b0;
               bus_err_s = 1'b1;
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = 1'b0;
            stall_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         stall_r    <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= 10'd0;
         wb_en_r    <= 1'b0;
         wb_addr_r  <= 3'd0;
         wb_data_r  <= 10'd0;
         fwd_r      <= 3'd0;
         bus_err_r  <= 1'b0;
         lat_wb_r   <= 1'b0;
         lat_dest_r <= 3'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         req_r      <= req_s;
         we_r       <= we_s;
         stall_r    <= stall_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
         wb_en_r    <= wb_en_s;
         wb_addr_r  <= wb_addr_s;
         wb_data_r  <= wb_data_s;
         fwd_r      <= fwd_s;
         bus_err_r  <= bus_err_s;
         lat_wb_r   <= lat_wb_s;
         lat_dest_r <= lat_dest_s;
      end
   end

   assign dmem.dmem_req   = req_r;
   assign dmem.dmem_we    = we_r;
   assign dmem.dmem_addr  = addr_r;
   assign dmem.dmem_wdata = wdata_r;
   assign stall           = stall_r;
   assign wb_en           = wb_en_r;
   assign wb_addr         = wb_addr_r;
   assign wb_data         = wb_data_r;
   assign fwd_src         = fwd_r;
   assign bus_err         = bus_err_r;
endmodule

// File: tb/tb_em_stage.sv
// Self-checking bench for em_stage: ALU vector table, directed memory sequences,
// and randomized traffic against an arithmetic reference model.
module tb_em_stage;
   localparam int AW  = 8;
   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] gp_rdata1_address, gp_rdata2_address, alu_ctrl;
   logic [9:0] aluA, aluB, store_data;
   logic       gp_reg_wb, mem_we, mem_re;
   logic       stall, wb_en, bus_err;
   logic [2:0] wb_addr, fwd_src;
   logic [9:0] wb_data;

   int compared   = 0;
   int mismatched = 0;

   em_stage_if #(.ADDR_W(AW)) dmem_bus ();

   em_stage #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .gp_rdata1_address(gp_rdata1_address), .gp_rdata2_address(gp_rdata2_address),
      .aluA(aluA), .aluB(aluB), .alu_ctrl(alu_ctrl), .gp_reg_wb(gp_reg_wb),
      .mem_we(mem_we), .mem_re(mem_re), .store_data(store_data),
      .dmem(dmem_bus.master),
      .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_src(fwd_src), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] a;
      logic [9:0] b;
      logic [2:0] op;
      logic       wb;
      logic [2:0] dest;
      logic [9:0] exp_data;
   } alu_vec_t;

   alu_vec_t vecs[12];

   // Reference ALU from arithmetic definitions of each operation.
   function automatic logic [9:0] ref_alu(input logic [9:0] a, input logic [9:0] b,
                                          input logic [2:0] op);
      int ia, ib, sa, sb, s, r;
      ia = int'(a);
      ib = int'(b);
      sa = (ia >= 512) ? ia - 1024 : ia;
      sb = (ib >= 512) ? ib - 1024 : ib;
      s  = ib % 16;
      case (op)
         3'd0:    r = (ia + ib) % 1024;
         3'd1:    r = (ia - ib + 1024) % 1024;
         3'd2:    r = ia & ib;
         3'd3:    r = ia | ib;
         3'd4:    r = ia ^ ib;
         3'd5:    r = (s >= 10) ? 0 : (ia * (1 << s)) % 1024;
         3'd6:    r = (s >= 10) ? 0 : ia / (1 << s);
         3'd7:    r = (sa < sb) ? 1 : 0;
         default: r = 0;
      endcase
      return r[9:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      gp_rdata1_address = 3'd0; gp_rdata2_address = 3'd0; alu_ctrl = 3'd0;
      aluA = 10'd0; aluB = 10'd0; store_data = 10'd0;
      gp_reg_wb = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 10'd0;
   endtask

   // One ALU instruction; exp is the expected result (from a table or the model).
   task automatic alu_instr(input logic [9:0] a, input logic [9:0] b, input logic [2:0] op,
                            input logic wb, input logic [2:0] dest, input logic [9:0] exp,
                            input string tag);
      logic [2:0] src;
      src = 3'($urandom);
      gp_rdata1_address = src; gp_rdata2_address = dest;
      aluA = a; aluB = b; alu_ctrl = op; gp_reg_wb = wb;
      mem_we = 1'b0; mem_re = 1'b0; store_data = 10'($urandom);
      step();
      check({tag, ".wb_en"}, 32'(wb_en), 32'(wb));
      check({tag, ".wb_addr"}, 32'(wb_addr), 32'(dest));
      check({tag, ".wb_data"}, 32'(wb_data), 32'(exp));
      check({tag, ".stall"}, 32'(stall), 32'd0);
      check({tag, ".req"}, 32'(dmem_bus.dmem_req), 32'd0);
      check({tag, ".bus_err"}, 32'(bus_err), 32'd0);
      check({tag, ".fwd_src"}, 32'(fwd_src), 32'(src));
   endtask

   // Memory instruction; ack arrives dly edges after acceptance (dly > TMO: never).
   task automatic mem_op(input logic we, input logic re, input logic [9:0] a,
                         input logic [9:0] b, input logic [2:0] op, input logic [9:0] sd,
                         input logic wb, input logic [2:0] dest, input int dly,
                         input logic [9:0] rd, input string tag);
      logic [9:0] ea;
      logic [2:0] src;
      logic       exp_wb;
      bit         err;
      int         done_k;
      ea  = ref_alu(a, b, op);
      src = 3'($urandom);
      gp_rdata1_address = src; gp_rdata2_address = dest;
      aluA = a; aluB = b; alu_ctrl = op; gp_reg_wb = wb;
      mem_we = we; mem_re = re; store_data = sd;
      dmem_bus.dmem_ack = 1'b0;
      step();
      check({tag, ".req0"}, 32'(dmem_bus.dmem_req), 32'd1);
      check({tag, ".stall0"}, 32'(stall), 32'd1);
      check({tag, ".we"}, 32'(dmem_bus.dmem_we), 32'(we));
      check({tag, ".addr"}, 32'(dmem_bus.dmem_addr), 32'(ea[AW-1:0]));
      check({tag, ".wdata"}, 32'(dmem_bus.dmem_wdata), 32'(sd));
      check({tag, ".wb_en0"}, 32'(wb_en), 32'd0);
      check({tag, ".fwd0"}, 32'(fwd_src), 32'(src));
      err    = (dly > TMO);
      done_k = err ? TMO : dly;
      exp_wb = re & ~we & wb & ~err;
      for (int k = 1; k <= done_k; k++) begin
         aluA = 10'($urandom); aluB = 10'($urandom); alu_ctrl = 3'($urandom);
         gp_rdata1_address = 3'($urandom); gp_rdata2_address = 3'($urandom);
         gp_reg_wb = 1'($urandom); mem_we = 1'($urandom); mem_re = 1'($urandom);
         store_data = 10'($urandom);
         dmem_bus.dmem_ack   = (k == dly);
         dmem_bus.dmem_rdata = (k == dly) ? rd : 10'($urandom);
         step();
         if (k < done_k) begin
            check({tag, ".req_hold"}, 32'(dmem_bus.dmem_req), 32'd1);
            check({tag, ".stall_hold"}, 32'(stall), 32'd1);
            check({tag, ".addr_hold"}, 32'(dmem_bus.dmem_addr), 32'(ea[AW-1:0]));
            check({tag, ".wb_en_hold"}, 32'(wb_en), 32'd0);
            check({tag, ".fwd_hold"}, 32'(fwd_src), 32'(src));
         end else begin
            check({tag, ".req_end"}, 32'(dmem_bus.dmem_req), 32'd0);
            check({tag, ".stall_end"}, 32'(stall), 32'd0);
            check({tag, ".bus_err"}, 32'(bus_err), 32'(err));
            check({tag, ".wb_en_end"}, 32'(wb_en), 32'(exp_wb));
            if (exp_wb) begin
               check({tag, ".wb_addr"}, 32'(wb_addr), 32'(dest));
               check({tag, ".wb_data"}, 32'(wb_data), 32'(rd));
            end
         end
      end
      dmem_bus.dmem_ack = 1'b0;
      mem_we = 1'b0; mem_re = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{10'h3FF, 10'h001, 3'd0, 1'b1, 3'd5, 10'h000};
      vecs[1]  = '{10'h000, 10'h001, 3'd1, 1'b1, 3'd5, 10'h3FF};
      vecs[2]  = '{10'h200, 10'h001, 3'd7, 1'b1, 3'd5, 10'h001};
      vecs[3]  = '{10'h3FF, 10'h00C, 3'd5, 1'b1, 3'd5, 10'h000};
      vecs[4]  = '{10'h3F0, 10'h0FF, 3'd2, 1'b1, 3'd1, 10'h0F0};
      vecs[5]  = '{10'h300, 10'h00F, 3'd3, 1'b1, 3'd2, 10'h30F};
      vecs[6]  = '{10'h3FF, 10'h155, 3'd4, 1'b1, 3'd7, 10'h2AA};
      vecs[7]  = '{10'h200, 10'h009, 3'd6, 1'b1, 3'd4, 10'h001};
      vecs[8]  = '{10'h001, 10'h009, 3'd5, 1'b1, 3'd6, 10'h200};
      vecs[9]  = '{10'h001, 10'h200, 3'd7, 1'b1, 3'd0, 10'h000};
      vecs[10] = '{10'h3FF, 10'h3FE, 3'd7, 1'b1, 3'd3, 10'h000};
      vecs[11] = '{10'h005, 10'h006, 3'd0, 1'b0, 3'd2, 10'h00B};

      idle_inputs();
      #2;
      check("rst.req", 32'(dmem_bus.dmem_req), 32'd0);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.wb_en", 32'(wb_en), 32'd0);
      check("rst.wb_data", 32'(wb_data), 32'd0);
      check("rst.addr", 32'(dmem_bus.dmem_addr), 32'd0);
      check("rst.bus_err", 32'(bus_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i])
         alu_instr(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].wb, vecs[i].dest,
                   vecs[i].exp_data, $sformatf("vec%0d", i));

      // Directed memory sequences.
      mem_op(1'b0, 1'b1, 10'd8, 10'd4, 3'd0, 10'd0, 1'b1, 3'd3, 3, 10'h155, "load");
      mem_op(1'b1, 1'b0, 10'd2, 10'd2, 3'd0, 10'h0AA, 1'b1, 3'd6, 1, 10'h123, "store");
      mem_op(1'b0, 1'b1, 10'd7, 10'd1, 3'd0, 10'd0, 1'b1, 3'd2, 99, 10'h000, "timeout");
      alu_instr(10'd20, 10'd22, 3'd0, 1'b1, 3'd1, 10'd42, "after_to");
      mem_op(1'b1, 1'b1, 10'd9, 10'd1, 3'd0, 10'h3C3, 1'b1, 3'd4, 2, 10'h111, "both");
      mem_op(1'b0, 1'b1, 10'd1, 10'd1, 3'd0, 10'd0, 1'b1, 3'd5, TMO, 10'h2F0, "ack_on_to");
      alu_instr(10'd1, 10'd1, 3'd0, 1'b1, 3'd0, 10'd2, "b2b");
      mem_op(1'b0, 1'b1, 10'd3, 10'd3, 3'd0, 10'd0, 1'b0, 3'd5, 2, 10'h0F0, "load_nowb");

      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 10'h3AB;
      alu_instr(10'd4, 10'd4, 3'd0, 1'b1, 3'd2, 10'd8, "stray_ack");
      dmem_bus.dmem_ack = 1'b0;

      // Asynchronous reset in the middle of an access.
      mem_op(1'b0, 1'b1, 10'd5, 10'd5, 3'd0, 10'd0, 1'b1, 3'd3, 99, 10'h000, "pre_rst");
      idle_inputs();
      mem_we = 1'b1; mem_re = 1'b0; gp_reg_wb = 1'b1;
      step();
      mem_we = 1'b0; gp_reg_wb = 1'b0;
      step();
      check("mid.req_before", 32'(dmem_bus.dmem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid.req", 32'(dmem_bus.dmem_req), 32'd0);
      check("mid.stall", 32'(stall), 32'd0);
      check("mid.wb_en", 32'(wb_en), 32'd0);
      check("mid.bus_err", 32'(bus_err), 32'd0);
      check("mid.addr", 32'(dmem_bus.dmem_addr), 32'd0);
      check("mid.wdata", 32'(dmem_bus.dmem_wdata), 32'd0);
      check("mid.wb_data", 32'(wb_data), 32'd0);
      check("mid.fwd", 32'(fwd_src), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      alu_instr(10'd100, 10'd28, 3'd1, 1'b1, 3'd7, 10'd72, "post_rst");

      // Randomized traffic against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [9:0] ra, rb, rsd, rrd;
         logic [2:0] rop, rdest;
         logic       rwb;
         ra = 10'($urandom); rb = 10'($urandom); rop = 3'($urandom);
         rdest = 3'($urandom); rwb = 1'($urandom);
         rsd = 10'($urandom); rrd = 10'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            dmem_bus.dmem_ack = 1'($urandom); dmem_bus.dmem_rdata = 10'($urandom);
            alu_instr(ra, rb, rop, rwb, rdest, ref_alu(ra, rb, rop), "rnd_alu");
            dmem_bus.dmem_ack = 1'b0;
         end else begin
            logic rwe, rre;
            rwe = 1'($urandom);
            rre = rwe ? 1'($urandom) : 1'b1;
            mem_op(rwe, rre, ra, rb, rop, rsd, rwb, rdest,
                   int'($urandom_range(1, TMO + 2)), rrd, "rnd_mem");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
